mux_rr_arbiter: RTL

- Four-requester round-robin arbiter that shares one 4:1 datapath mux between four sources.
- Each source uses a req/gnt handshake. The arbiter picks the mux select, captures the winning word into a registered output stage, and presents it downstream with a valid/ready handshake.
- It sits in front of the 4:1 mux path, so the shared resource is sequenced rather than statically selected.

---
 rtl/mux_rr_arbiter.sv | 72 +++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Four-source round-robin arbiter feeding one registered 4:1 mux stage; 1 cycle grant-to-data_out.
// Backpressure: with out_valid & !out_ready all grants are withheld and output, pointer and count hold.
module mux_rr_arbiter #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] data_in,
    output logic [3:0]     gnt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   data_out,
    output logic [1:0]     sel,
    output logic [CW-1:0]  xfer_cnt
);

    logic [1:0]   ptr;
    logic [1:0]   idx;
    logic [1:0]   win_idx;
    logic         win_found;
    logic [W-1:0] win_dat;
    logic         accept;
    logic         take;

    assign accept = !out_valid || out_ready;
    assign take   = accept && win_found;

    // Scan from the farthest offset down so the slot closest to ptr overrides.
    always_comb begin
        idx       = ptr;
        win_idx   = ptr;
        win_found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win_idx   = idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        win_dat = '0;
        for (int i = 0; i < 4; i++) begin
            if (win_idx == 2'(i)) win_dat = data_in[i*W +: W];
        end
    end

    // Grant is gated by rst_n so it reads zero during an asynchronous reset.
    assign gnt = (take && rst_n) ? (4'b0001 << win_idx) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sel       <= 2'd0;
            ptr       <= 2'd0;
            xfer_cnt  <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            data_out  <= win_dat;
            sel       <= win_idx;
            ptr       <= win_idx + 2'd1;
            if (xfer_cnt != {CW{1'b1}}) xfer_cnt <= xfer_cnt + 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
